// File: rtl/imem_loader.sv
// Instruction-memory loader: frames a UART byte stream into LE 32-bit words.
// Ports: rx_* byte handshake in, wr_* memory write port, cpu_stall/load_*/words_loaded status.
module imem_loader #(
  parameter int          DEPTH          = 128,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [31:0]                wr_data,
  output logic                       cpu_stall,
  output logic                       load_done,
  output logic                       load_err,
  output logic [$clog2(DEPTH):0]     words_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]    DEPTH_B = 9'(DEPTH);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WR, S_CSUM, S_ERR
  } state_t;

  state_t        state_q;
  logic [AW:0]   n_q;
  logic [AW:0]   words_q;
  logic [1:0]    bidx_q;
  logic [23:0]   buf_q;
  logic [7:0]    csum_q;
  logic [TW-1:0] tcnt_q;
  logic          rx_ready_q;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [31:0]   wr_data_q;
  logic          stall_q;
  logic          done_q;
  logic          err_q;

  logic accept;
  logic in_frame;
  logic abort;

  assign accept   = rx_valid && rx_ready_q;
  assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) ||
                    (state_q == S_WR)  || (state_q == S_CSUM);

  // Every path into ERR: idle timeout, oversize LEN, checksum mismatch.
  always_comb begin
    abort = 1'b0;
    if (in_frame && !accept && tcnt_q == T_LAST)
      abort = 1'b1;
    if (state_q == S_LEN && accept && {1'b0, rx_data} > DEPTH_B)
      abort = 1'b1;
    if (state_q == S_CSUM && accept && rx_data != csum_q)
      abort = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      words_q    <= '0;
      bidx_q     <= '0;
      buf_q      <= '0;
      csum_q     <= '0;
      tcnt_q     <= '0;
      rx_ready_q <= 1'b1;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (accept)
        tcnt_q <= '0;
      else if (in_frame)
        tcnt_q <= tcnt_q + TW'(1);

      if (abort) begin
        state_q    <= S_ERR;
        err_q      <= 1'b1;
        stall_q    <= 1'b0;
        rx_ready_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (accept && rx_data == HEADER) begin
              state_q <= S_LEN;
              stall_q <= 1'b1;
              done_q  <= 1'b0;
              err_q   <= 1'b0;
              words_q <= '0;
            end
          end
          S_LEN: begin
            if (accept) begin
              n_q     <= (rx_data == 8'd0) ? (AW+1)'(DEPTH)
                                           : (AW+1)'(rx_data);
              bidx_q  <= '0;
              csum_q  <= '0;
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            if (accept) begin
              csum_q <= csum_q ^ rx_data;
              buf_q  <= {rx_data, buf_q[23:8]};
              bidx_q <= bidx_q + 2'd1;
              if (bidx_q == 2'd3) begin
                // Write cycle: hold off the next byte so wr_en never repeats.
                wr_en_q    <= 1'b1;
                wr_addr_q  <= words_q[AW-1:0];
                wr_data_q  <= {rx_data, buf_q};
                words_q    <= words_q + (AW+1)'(1);
                rx_ready_q <= 1'b0;
                state_q    <= S_WR;
              end
            end
          end
          S_WR: begin
            rx_ready_q <= 1'b1;
            state_q    <= (words_q == n_q) ? S_CSUM : S_DATA;
          end
          S_CSUM: begin
            if (accept) begin
              done_q  <= 1'b1;
              stall_q <= 1'b0;
              state_q <= S_IDLE;
            end
          end
          S_ERR: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rx_ready     = rx_ready_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign cpu_stall    = stall_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of framed images plus timeout and reset sequences.
// Expected words come from a byte-pattern model; writes captured by a monitor.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_stall;
  logic        load_done;
  logic        load_err;
  logic [7:0]  words_loaded;

  imem_loader #(
    .DEPTH(128),
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_stall(cpu_stall),
    .load_done(load_done),
    .load_err(load_err),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  len;
    int          nw;
    int          mode;
    logic [7:0]  seed;
    bit          garbage;
    bit          send_csum;
    bit          bad_csum;
    logic        exp_done;
    logic        exp_err;
    int          exp_words;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs[7];

  int passed = 0;
  int total  = 0;

  logic [6:0]  wa[$];
  logic [31:0] wd[$];
  int          dbl_viol = 0;
  int          rdy_viol = 0;
  logic        prev_wr  = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        wa.push_back(wr_addr);
        wd.push_back(wr_data);
      end
      if (wr_en && prev_wr) dbl_viol++;
      if (rx_ready == wr_en) rdy_viol++;
      prev_wr = wr_en;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [7:0] pbyte(input vec_t v, input int i);
    logic [7:0] b;
    b = 8'h00;
    if (v.mode == 0) begin
      case (i)
        0: b = 8'h13; 1: b = 8'h05; 2: b = 8'h00; 3: b = 8'h00;
        4: b = 8'h93; 5: b = 8'h05; 6: b = 8'h10; 7: b = 8'h00;
        default: b = 8'h00;
      endcase
    end else if (v.mode == 1) begin
      b = v.seed + 8'(i);
    end else begin
      b = v.seed;
    end
    return b;
  endfunction

  function automatic logic [31:0] mword(input vec_t v, input int w);
    return {pbyte(v, 4*w+3), pbyte(v, 4*w+2),
            pbyte(v, 4*w+1), pbyte(v, 4*w)};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL handshake: rx_ready stuck low, got 0 expected 1");
    end
    @(posedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    chk({tag, "_wr_data"}, wr_data, 32'd0);
    chk({tag, "_stall"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_done"}, 32'(load_done), 32'd0);
    chk({tag, "_err"}, 32'(load_err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [7:0] cs;
    int mism;
    string tag;
    tag = $sformatf("v%0d", id);
    wa.delete();
    wd.delete();
    if (v.garbage) begin
      send_byte(8'h00);
      send_byte(8'hFF);
    end
    send_byte(8'hA5);
    send_byte(v.len);
    if (v.nw > 0) begin
      #1;
      chk({tag, "_stall_in_frame"}, 32'(cpu_stall), 32'd1);
    end
    cs = 8'h00;
    for (int i = 0; i < 4*v.nw; i++) begin
      cs ^= pbyte(v, i);
      send_byte(pbyte(v, i));
    end
    if (v.send_csum) send_byte(v.bad_csum ? (cs ^ 8'h01) : cs);
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_done"}, 32'(load_done), 32'(v.exp_done));
    chk({tag, "_err"}, 32'(load_err), 32'(v.exp_err));
    chk({tag, "_stall_end"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(v.exp_words));
    repeat (2) @(negedge clk);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(v.exp_words));
    if (v.exp_words > 0 && wd.size() > 0)
      chk({tag, "_w0"}, wd[0], v.exp_w0);
    mism = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 7'(i) || wd[i] !== mword(v, i)) mism++;
    chk({tag, "_data_mism"}, 32'(mism), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{8'h02, 2, 0, 8'h00, 0, 1, 0, 1'b1, 1'b0, 2, 32'h00000513};
    vecs[1] = '{8'h02, 2, 0, 8'h00, 0, 1, 1, 1'b0, 1'b1, 2, 32'h00000513};
    vecs[2] = '{8'h00, 128, 1, 8'h00, 0, 1, 0, 1'b1, 1'b0, 128, 32'h03020100};
    vecs[3] = '{8'h81, 0, 1, 8'h00, 0, 0, 0, 1'b0, 1'b1, 0, 32'h0};
    vecs[4] = '{8'h03, 3, 1, 8'h40, 1, 1, 0, 1'b1, 1'b0, 3, 32'h43424140};
    vecs[5] = '{8'h01, 1, 2, 8'hA5, 0, 1, 0, 1'b1, 1'b0, 1, 32'hA5A5A5A5};
    vecs[6] = '{8'h80, 128, 1, 8'h10, 0, 1, 0, 1'b1, 1'b0, 128, 32'h13121110};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], k);

    // Idle timeout after 3 payload bytes.
    wa.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    rx_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      if (k == 15) chk("tmo_err_at_15", 32'(load_err), 32'd0);
      if (k == 16) begin
        chk("tmo_err_at_16", 32'(load_err), 32'd1);
        chk("tmo_stall", 32'(cpu_stall), 32'd0);
      end
    end
    repeat (3) @(negedge clk);
    chk("tmo_nwrites", 32'(wa.size()), 32'd0);

    // Reset right after word 0 is written.
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    rx_valid = 1'b0;
    n = 0;
    while (!wr_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_wr_seen", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    @(negedge clk);
    rst = 1'b0;
    prev_wr = 1'b0;
    run_vec(vecs[0], 7);

    chk("wr_en_back_to_back", 32'(dbl_viol), 32'd0);
    chk("rx_ready_vs_wr_en", 32'(rdy_viol), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction memory. It receives a framed program image as a byte stream from the UART receiver and assembles little-endian 32-bit words. Each word goes out on a synchronous write port that feeds the instruction memory's write side. While a load is in progress it holds the CPU in stall, and it reports completion or error status to the debug/VGA logic.

Parameters:
DEPTH, 128, instruction memory depth in words; address width is clog2(DEPTH).
HEADER, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a frame before aborting.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  byte available
rx_ready  out  1  loader accepts byte; transfer occurs when rx_valid && rx_ready on a clk edge
wr_en  out  1  one-cycle memory write strobe
wr_addr  out  7  word address, equal to byte address bits [8:2]
wr_data  out  32  word to write
cpu_stall  out  1  high while a frame is in progress
load_done  out  1  sticky: last frame loaded and checksum OK
load_err  out  1  sticky: last frame aborted
words_loaded  out  8  count of words written in current/last frame (0..128)

Behaviour:
- Reset values: rx_ready=1, wr_en=0, wr_addr=0, wr_data=0, cpu_stall=0, load_done=0, load_err=0, words_loaded=0, state=IDLE. Reset mid-frame abandons the frame; already-written words are not undone.
- Frame format: HEADER, LEN, 4*N payload bytes, CSUM.
  - LEN=0 means N=DEPTH (128); otherwise N=LEN, and LEN>DEPTH is an error.
  - Payload is little-endian: the first byte is wdata[7:0].
  - CSUM is the XOR of all payload bytes.
- States:
  - IDLE: non-HEADER bytes are accepted and discarded. On HEADER -> LEN, set cpu_stall=1, clear load_done/load_err/words_loaded.
  - LEN: on byte, if LEN>DEPTH -> ERR; else latch N -> DATA, byte index 0, address 0, checksum 0.
  - DATA: shift each byte into the word buffer and XOR it into the checksum.
    - After the 4th byte of a word, the next cycle drives wr_en=1 with wr_addr = word index and wr_data = assembled word. words_loaded increments in the same cycle.
    - rx_ready=0 during that wr_en cycle only, so at most one byte per two cycles at word boundaries.
    - After word N is written -> CSUM.
  - CSUM: on byte, if it equals the running XOR -> IDLE with load_done=1; else -> ERR.
  - ERR: set load_err=1, cpu_stall=0 -> IDLE in the next cycle.
  - On every exit to IDLE, cpu_stall=0 on the same cycle load_done/load_err rise.
- Timeout: an idle counter resets on every accepted byte and counts while in LEN/DATA/CSUM. Reaching TIMEOUT_CYCLES -> ERR. The counter is inactive in IDLE.
- HEADER bytes inside a frame are ordinary data and do not restart the frame.
- wr_addr never exceeds N-1. Address wrap cannot occur because LEN>DEPTH is rejected.
- Words written before an error remain in memory; load_err signals that the image is incomplete.
- wr_en is never high for two consecutive cycles.

Test Plan:
- Nominal frame: A5, 02, bytes 13 05 00 00 93 05 10 00, CSUM = XOR of all payload bytes.
  - Required: wr_en pulses at addr 0 with data 32'h00000513, then addr 1 with 32'h00100593.
  - Required: words_loaded=2, load_done=1, cpu_stall low after CSUM.
- Bad checksum: same frame with CSUM^8'h01.
  - Required: both writes occur, load_err=1, load_done=0, cpu_stall=0.
- LEN=0: feed 512 payload bytes with incrementing pattern plus a correct CSUM.
  - Required: 128 writes at addrs 0..127, words_loaded=128, load_done=1.
  - LEN=8'h81 -> load_err=1 and no wr_en.
- Backpressure/handshake: hold rx_valid continuously.
  - Required: rx_ready drops exactly on each wr_en cycle and no byte is lost or duplicated.
  - Garbage bytes 00, FF before HEADER are ignored.
- Timeout (TIMEOUT_CYCLES=16): stop after 3 payload bytes.
  - Required: load_err=1 exactly 16 cycles after the last accepted byte, and no wr_en.
- Reset mid-frame: assert rst after word 0 is written.
  - Required: all outputs return immediately to reset values.
  - A subsequent full frame loads correctly from addr 0.
